// File: rtl/calc2_port_driver.sv
// calc2_port_driver
//
// Request-issue and response-tracking stage for one calc2 port. Accepts whole
// operations (command + two operands) on a valid/ready handshake. Serialises each
// one onto the DUT request pins as a two-cycle transfer:
//   - cycle 1: cmd, data1 and tag
//   - cycle 2: data2
// Tracks busy tags and returns each DUT response tagged with its original command.
//
// Optional feature: define CALC2_DRV_TIMEOUT_EN to enable per-tag watchdog counters.
// A tag that stays busy for TIMEOUT_CYCLES cycles is freed and reported with
// rsp_resp = 3.
//
// Ports:
//   c_clk, reset            clock; synchronous active-low reset
//   op_valid/op_ready       operation handshake; op_cmd, op_data1, op_data2 payload
//   req_cmd_in/data_in/tag  request pins driven into the DUT
//   out_resp/data/tag       response pins sampled from the DUT (out_resp 0 = none)
//   rsp_valid/resp/data/    one-cycle response pulse with the originating command
//     tag/cmd
//   outstanding             number of busy tags
//   err_spurious            sticky flag: a response arrived for a non-busy tag

module calc2_port_driver #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_cmd,
  input  logic [31:0] op_data1,
  input  logic [31:0] op_data2,
  output logic [3:0]  req_cmd_in,
  output logic [31:0] req_data_in,
  output logic [1:0]  req_tag_in,
  input  logic [1:0]  out_resp,
  input  logic [31:0] out_data,
  input  logic [1:0]  out_tag,
  output logic        rsp_valid,
  output logic [1:0]  rsp_resp,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_tag,
  output logic [3:0]  rsp_cmd,
  output logic [2:0]  outstanding,
  output logic        err_spurious
);

  localparam int unsigned NumTags = 4;

  typedef enum logic [1:0] {StIdle, StCmd, StData2} state_e;

  state_e      state_q, state_d;
  logic        run_q;  // low until the first edge with reset released
  logic [3:0]  busy_q, busy_d;
  logic [3:0]  cmd_tbl_q [NumTags];
  logic [3:0]  cmd_q;
  logic [31:0] data1_q, data2_q;
  logic [1:0]  tag_q;
  logic        rsp_valid_q;
  logic [1:0]  rsp_resp_q, rsp_tag_q;
  logic [31:0] rsp_data_q;
  logic [3:0]  rsp_cmd_q;
  logic        err_q;

  logic        have_free;
  logic [1:0]  free_tag;
  logic        hs;
  logic        rsp_hit, rsp_spur;
  logic        exp_any;
  logic [1:0]  exp_tag;
  logic        rpt_to;

  // Lowest-index free tag among those in use, from the registered bitmap.
  always_comb begin
    have_free = 1'b0;
    free_tag  = '0;
    for (int i = int'(MAX_OUTSTANDING) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        have_free = 1'b1;
        free_tag  = 2'(i);
      end
    end
  end

  assign op_ready = run_q && (state_q != StCmd) && have_free;
  assign hs       = op_valid && op_ready;
  assign rsp_hit  = (out_resp != 2'd0) && busy_q[out_tag];
  assign rsp_spur = (out_resp != 2'd0) && !busy_q[out_tag];

`ifdef CALC2_DRV_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q [NumTags];

  // Counters saturate at the limit so an expiry blocked by a DUT response waits.
  always_ff @(posedge c_clk) begin
    for (int i = 0; i < int'(NumTags); i++) begin
      if (!reset) begin
        cnt_q[i] <= '0;
      end else if (hs && (free_tag == 2'(i))) begin
        cnt_q[i] <= '0;
      end else if (busy_q[i] && (cnt_q[i] != CntW'(TIMEOUT_CYCLES))) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    exp_any = 1'b0;
    exp_tag = '0;
    for (int i = int'(NumTags) - 1; i >= 0; i--) begin
      if (busy_q[i] && (cnt_q[i] == CntW'(TIMEOUT_CYCLES))) begin
        exp_any = 1'b1;
        exp_tag = 2'(i);
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign exp_any        = 1'b0;
  assign exp_tag        = '0;
`endif

  // A genuine DUT response takes the response slot; an expiry waits a cycle.
  assign rpt_to = exp_any && !rsp_hit;

  always_comb begin
    busy_d = busy_q;
    if (rsp_hit) begin
      busy_d[out_tag] = 1'b0;
    end else if (rpt_to) begin
      busy_d[exp_tag] = 1'b0;
    end
    if (hs) begin
      busy_d[free_tag] = 1'b1;
    end
  end

  // Issue FSM: state register.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = hs ? StCmd : StIdle;
      StCmd:   state_d = StData2;
      StData2: state_d = hs ? StCmd : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Issue FSM: request pin outputs.
  always_comb begin
    req_cmd_in  = '0;
    req_data_in = '0;
    req_tag_in  = '0;
    unique case (state_q)
      StCmd: begin
        req_cmd_in  = cmd_q;
        req_data_in = data1_q;
        req_tag_in  = tag_q;
      end
      StData2: begin
        req_data_in = data2_q;
      end
      default: ;
    endcase
  end

  // Operation capture, tag tracking and response registers.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      run_q       <= 1'b0;
      busy_q      <= '0;
      cmd_q       <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_resp_q  <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_cmd_q   <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < int'(NumTags); i++) begin
        cmd_tbl_q[i] <= '0;
      end
    end else begin
      run_q  <= 1'b1;
      busy_q <= busy_d;
      if (hs) begin
        cmd_q               <= op_cmd;
        data1_q             <= op_data1;
        data2_q             <= op_data2;
        tag_q               <= free_tag;
        cmd_tbl_q[free_tag] <= op_cmd;
      end
      rsp_valid_q <= rsp_hit || rpt_to;
      if (rsp_hit) begin
        rsp_resp_q <= out_resp;
        rsp_data_q <= out_data;
        rsp_tag_q  <= out_tag;
        rsp_cmd_q  <= cmd_tbl_q[out_tag];
      end else if (rpt_to) begin
        rsp_resp_q <= 2'd3;
        rsp_data_q <= '0;
        rsp_tag_q  <= exp_tag;
        rsp_cmd_q  <= cmd_tbl_q[exp_tag];
      end else begin
        rsp_resp_q <= '0;
        rsp_data_q <= '0;
        rsp_tag_q  <= '0;
        rsp_cmd_q  <= '0;
      end
      if (rsp_spur) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < int'(NumTags); i++) begin
      outstanding = outstanding + 3'(busy_q[i]);
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_resp     = rsp_resp_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_tag      = rsp_tag_q;
  assign rsp_cmd      = rsp_cmd_q;
  assign err_spurious = err_q;

endmodule

// File: doc/calc2_port_driver.md
# calc2_port_driver

Request-issue and response-tracking stage for one calc2 port, sitting directly upstream of the calc2 DUT inside the bench wrapper. It accepts whole operations (command plus two operands) on a valid/ready input. It serialises each operation onto the DUT's req*_cmd_in / req*_data_in / req*_tag_in pins using the two-cycle calc2 request protocol. It allocates and tracks tags and returns each DUT response with the originating command attached. One instance per port; four instances cover calc2_top.

## Interface
- MAX_OUTSTANDING, 4, number of tags in use (1..4); tags 0..MAX_OUTSTANDING-1.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with CALC2_DRV_TIMEOUT_EN.
- c_clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- op_valid  in  1  operation offered.
- op_ready  out  1  operation accepted when op_valid && op_ready at an edge.
- op_cmd  in  4  calc2 command (1 add, 2 sub, 5 shl, 6 shr; others passed through).
- op_data1  in  32  operand 1.
- op_data2  in  32  operand 2.
- req_cmd_in  out  4  to DUT reqN_cmd_in.
- req_data_in  out  32  to DUT reqN_data_in.
- req_tag_in  out  2  to DUT reqN_tag_in.
- out_resp  in  2  from DUT out_respN (0 = none).
- out_data  in  32  from DUT out_dataN.
- out_tag  in  2  from DUT out_tagN.
- rsp_valid  out  1  one-cycle pulse; no backpressure.
- rsp_resp  out  2  response code (1 ok, 2 error, 3 timeout).
- rsp_data  out  32  result.
- rsp_tag  out  2  tag.
- rsp_cmd  out  4  command originally issued with that tag.
- outstanding  out  3  count of busy tags.
- err_spurious  out  1  sticky; a response arrived for a non-busy tag.

## Operation
- Issue FSM states:
  - IDLE: all req_* outputs 0.
  - CMD: req_cmd_in = cmd, req_data_in = data1, req_tag_in = tag.
  - DATA2: req_cmd_in = 0, req_data_in = data2, req_tag_in = 0.
- op_ready = (state != CMD) && (at least one free tag). The free-tag check uses the registered busy bitmap.
- Transitions:
  - Handshake in IDLE or DATA2 → CMD.
  - CMD → DATA2 unconditionally.
  - DATA2 without a handshake → IDLE.
- Back-to-back operations issue one command every 2 cycles.
- At the handshake edge:
  - The lowest-index free tag is marked busy.
  - cmd, data1 and data2 are registered.
  - cmd is written into the per-tag command table.
- Response capture: at an edge with out_resp != 0:
  - If out_tag is busy: the tag is freed, and the next cycle gives rsp_valid = 1 with rsp_resp/data/tag = sampled values and rsp_cmd = table[out_tag].
  - If out_tag is not busy: err_spurious is set, no rsp_valid, and the bitmap is unchanged.
- A tag freed at edge E becomes allocatable from edge E+1 onward. It is never reused at E itself.
- outstanding = popcount(busy); it is updated on the same edges as the bitmap.
- Reset (reset = 0 at an edge):
  - State goes to IDLE; bitmap, table and err_spurious are cleared.
  - All outputs are 0, including op_ready, while reset is held.
  - Reset mid-operation drops all in-flight requests silently.

## Timing
- Handshake at edge N:
  - Command/operand 1 are on the DUT pins during cycle N→N+1.
  - Operand 2 is on the DUT pins during N+1→N+2.
- Response sampled at edge M → rsp_valid high during M→M+1. Latency is 1 cycle.
- The first op_ready = 1 comes in the cycle after reset deasserts.

## Configuration
- CALC2_DRV_TIMEOUT_EN defined:
  - Each busy tag has a counter of width $clog2(TIMEOUT_CYCLES+1), cleared at allocation and incremented every cycle while the tag is busy.
  - When a counter reaches TIMEOUT_CYCLES, the tag expires:
    - The tag is freed.
    - rsp_valid is pulsed with rsp_resp = 3, rsp_data = 0 and rsp_cmd from the table.
  - Collisions:
    - A DUT response in the same cycle has priority; the expired tag holds its count and reports next cycle.
    - Multiple expiries report lowest tag first, one per cycle.
  - A DUT response arriving later for a timed-out tag counts as spurious.
- Undefined: no counters; TIMEOUT_CYCLES is ignored; rsp_resp = 3 is never produced.

## Test plan
- Reset: hold reset = 0 for 2 cycles with op_valid = 1.
  - During reset: all outputs 0 and op_ready = 0.
  - After release: op_ready = 1 one cycle later.
- Single add: op (1, 5, 7) accepted at edge N.
  - N+1: req_cmd_in = 1, req_data_in = 5, req_tag_in = 0.
  - N+2: cmd 0, data 7.
  - DUT returns resp 1, data 12, tag 0 → rsp_valid with rsp_data = 12, rsp_tag = 0, rsp_cmd = 1; outstanding back to 0.
- Fill: 4 ops offered continuously with no responses.
  - Tags 0, 1, 2, 3 issue 2 cycles apart; then op_ready = 0 and outstanding = 4.
  - Respond on tag 2 → the next op gets tag 2.
- Spurious: out_resp = 1, out_tag = 3 with nothing outstanding → err_spurious = 1 (sticky), no rsp_valid.
- Timeout (macro on, TIMEOUT_CYCLES = 16): op accepted at edge N with no response.
  - rsp_valid with rsp_resp = 3 and rsp_tag = 0 during N+17.
  - A late DUT response on tag 0 sets err_spurious.
- Reset mid-op: reset = 0 during DATA2 with 2 tags busy → next cycle req_* = 0, outstanding = 0, no rsp_valid.
